// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder and the memory stage.
// State encoding, access size codes and SRAM latency bounds.
package dmem_defs;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 7;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef struct packed {
      logic        we;
      logic [0:31] addr;
      logic [0:31] wdata;
      logic [0:2]  info;
   } dmem_req_t;

   function automatic logic misaligned(
      input logic [0:1] size,
      input logic [0:1] lane
   );
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[1];
         SZ_WORD: bad = (lane != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian byte-lane steering: byte enables, store replication
// and load extraction with sign/zero extension.
module dmem_lane_align
   import dmem_defs::*;
(
   input  logic [0:1]  size,
   input  logic        uns,
   input  logic [0:1]  lane,
   input  logic [0:31] wdata,
   input  logic [0:31] word,
   output logic [0:3]  be,
   output logic [0:31] wdata_rep,
   output logic [0:31] rdata_ext
);

   logic [0:7]  rbyte;
   logic [0:15] rhalf;

   always_comb begin
      rbyte = word[0:7];
      unique case (lane)
         2'd0: rbyte = word[0:7];
         2'd1: rbyte = word[8:15];
         2'd2: rbyte = word[16:23];
         2'd3: rbyte = word[24:31];
      endcase
      rhalf = lane[0] ? word[16:31] : word[0:15];
   end

   always_comb begin
      be        = '0;
      wdata_rep = '0;
      rdata_ext = word;
      unique case (size)
         SZ_BYTE: begin
            be        = 4'b1000 >> lane;
            wdata_rep = {4{wdata[24:31]}};
            rdata_ext = uns ? {24'h0, rbyte}
                            : {{24{rbyte[0]}}, rbyte};
         end
         SZ_HALF: begin
            be        = lane[0] ? 4'b0011 : 4'b1100;
            wdata_rep = {2{wdata[16:31]}};
            rdata_ext = uns ? {16'h0, rhalf}
                            : {{16{rhalf[0]}}, rhalf};
         end
         SZ_WORD: begin
            be        = 4'b1111;
            wdata_rep = wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data responder: one SRAM access per request with a
// fixed read latency, misalignment trap and pipeline stall.
module dmem_responder
   import dmem_defs::*;
#(
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [0:31] addr,
   input  logic [0:31] wdata,
   input  logic [0:2]  dmem_info,
   output logic [0:31] rdata,
   output logic        done,
   output logic        misalign,
   output logic        reg_lock,
   output logic        sram_en,
   output logic        sram_we,
   output logic [0:29] sram_addr,
   output logic [0:3]  sram_be,
   output logic [0:31] sram_wdata,
   input  logic [0:31] sram_rdata
);

   state_t           state;
   dmem_req_t        cur;
   logic [CNT_W-1:0] cnt;
   logic             err;
   logic [0:3]       be;
   logic [0:31]      wrep;
   logic [0:31]      rext;

   dmem_lane_align u_align (
      .size      (cur.info[0:1]),
      .uns       (cur.info[2]),
      .lane      (cur.addr[30:31]),
      .wdata     (cur.wdata),
      .word      (sram_rdata),
      .be        (be),
      .wdata_rep (wrep),
      .rdata_ext (rext)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         err     <= 1'b0;
         rdata   <= '0;
         done    <= 1'b0;
         sram_en <= 1'b0;
      end else begin
         done    <= 1'b0;
         sram_en <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (req) begin
                  cur <= '{we, addr, wdata, dmem_info};
                  if (misaligned(dmem_info[0:1], addr[30:31])) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     rdata <= '0;
                     state <= ST_DONE;
                  end else begin
                     err     <= 1'b0;
                     sram_en <= 1'b1;
                     state   <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (cur.we) begin
                  done  <= 1'b1;
                  rdata <= '0;
                  state <= ST_DONE;
               end else begin
                  cnt   <= CNT_W'(LATENCY);
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 1'b1;
               // sram_rdata is valid on the cycle the count hits 1
               if (cnt == CNT_W'(1)) begin
                  rdata <= rext;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
         endcase
      end
   end

   assign misalign   = done & err;
   assign sram_we    = sram_en & cur.we;
   assign sram_addr  = cur.addr[0:29];
   assign sram_be    = sram_en ? be : '0;
   assign sram_wdata = sram_en ? wrep : '0;

   always_comb begin
      reg_lock = 1'b0;
      unique case (state)
         ST_IDLE:  reg_lock = req;
         ST_ISSUE: reg_lock = 1'b1;
         ST_WAIT:  reg_lock = 1'b1;
         ST_DONE:  reg_lock = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed vector bench for dmem_responder (LATENCY 2 and 7 instances)
// with a latency-exact SRAM read pipe.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset2, reset7, sel7;
   logic        req, we;
   logic [0:31] addr, wdata, rd_word, srd;
   logic [0:2]  info;

   logic [0:31] rdata2, rdata7, wd2, wd7;
   logic        done2, done7, mis2, mis7, lock2, lock7;
   logic        en2, en7, swe2, swe7;
   logic [0:29] sa2, sa7;
   logic [0:3]  be2, be7;

   dmem_responder #(.LATENCY(2)) dut2 (
      .clk(clk), .reset(reset2), .req(req), .we(we),
      .addr(addr), .wdata(wdata), .dmem_info(info),
      .rdata(rdata2), .done(done2), .misalign(mis2),
      .reg_lock(lock2), .sram_en(en2), .sram_we(swe2),
      .sram_addr(sa2), .sram_be(be2), .sram_wdata(wd2),
      .sram_rdata(srd)
   );

   dmem_responder #(.LATENCY(7)) dut7 (
      .clk(clk), .reset(reset7), .req(req), .we(we),
      .addr(addr), .wdata(wdata), .dmem_info(info),
      .rdata(rdata7), .done(done7), .misalign(mis7),
      .reg_lock(lock7), .sram_en(en7), .sram_we(swe7),
      .sram_addr(sa7), .sram_be(be7), .sram_wdata(wd7),
      .sram_rdata(srd)
   );

   logic [0:31] a_rd, a_wd;
   logic        a_done, a_mis, a_lock, a_en, a_swe;
   logic [0:29] a_sa;
   logic [0:3]  a_be;
   int          lat_act;

   assign a_rd    = sel7 ? rdata7 : rdata2;
   assign a_wd    = sel7 ? wd7 : wd2;
   assign a_done  = sel7 ? done7 : done2;
   assign a_mis   = sel7 ? mis7 : mis2;
   assign a_lock  = sel7 ? lock7 : lock2;
   assign a_en    = sel7 ? en7 : en2;
   assign a_swe   = sel7 ? swe7 : swe2;
   assign a_sa    = sel7 ? sa7 : sa2;
   assign a_be    = sel7 ? be7 : be2;
   assign lat_act = sel7 ? 7 : 2;

   // SRAM read pipe: data is only valid exactly lat_act cycles after a read
   logic [0:31] pd[8];
   logic        pv[8] = '{default: 1'b0};

   always @(posedge clk) begin
      for (int i = 7; i > 0; i--) begin
         pv[i] <= pv[i-1];
         pd[i] <= pd[i-1];
      end
      pv[0] <= a_en & ~a_swe;
      pd[0] <= rd_word;
   end

   always_comb begin
      srd = 32'hA5A5_A5A5;
      if (pv[lat_act-1]) srd = pd[lat_act-1];
   end

   typedef struct {
      logic        we;
      logic [0:31] addr;
      logic [0:31] wdata;
      logic [0:2]  info;
      logic [0:31] mem;
      logic [0:3]  be;
      logic [0:31] swd;
      logic [0:31] rd;
      logic        mis;
   } vec_t;

   vec_t vt[12];
   int   n_vec = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int lat, input string nm);
      int          exp_done, done_cyc, n_en, n_done;
      logic        lock_ok, zero_ok, g_we, g_mis;
      logic [0:3]  g_be;
      logic [0:31] g_wd, g_rd;
      logic [0:29] g_sa;
      exp_done = v.mis ? 1 : (v.we ? 2 : 2 + lat);
      done_cyc = -1; n_en = 0; n_done = 0;
      lock_ok = 1'b1; zero_ok = 1'b1;
      g_we = 1'b0; g_mis = 1'b0; g_be = '0; g_wd = '0; g_sa = '0;
      g_rd = ~v.rd;
      n_vec++;
      @(negedge clk);
      req = 1'b1; we = v.we; addr = v.addr; wdata = v.wdata;
      info = v.info; rd_word = v.mem;
      for (int c = 0; c <= exp_done + 2; c++) begin
         #1;
         if (a_lock !== (c < exp_done)) lock_ok = 1'b0;
         if (a_en) begin
            n_en++;
            g_be = a_be; g_wd = a_wd; g_we = a_swe; g_sa = a_sa;
         end else if (a_swe || a_be != 0 || a_wd != 0) begin
            zero_ok = 1'b0;
         end
         if (a_done) begin
            n_done++; done_cyc = c; g_rd = a_rd; g_mis = a_mis;
         end
         @(negedge clk);
         if (c == exp_done) req = 1'b0;
      end
      #1;
      chk({nm, " done_cycle"}, done_cyc, exp_done);
      chk({nm, " done_count"}, n_done, 1);
      chk({nm, " misalign"}, g_mis, v.mis);
      chk({nm, " rdata"}, g_rd, v.rd);
      chk({nm, " rdata_hold"}, a_rd, v.rd);
      chk({nm, " sram_en_count"}, n_en, v.mis ? 0 : 1);
      chk({nm, " reg_lock"}, lock_ok, 1);
      chk({nm, " idle_zero"}, zero_ok, 1);
      if (!v.mis) begin
         chk({nm, " sram_be"}, g_be, v.be);
         chk({nm, " sram_wdata"}, g_wd, v.swd);
         chk({nm, " sram_we"}, g_we, v.we);
         chk({nm, " sram_addr"}, g_sa, v.addr[0:29]);
      end
   endtask

   initial begin
      int          n_done;
      logic [15:0] dmask, emask;
      logic [0:31] b2b_rd;
      vec_t        v7;

      vt[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 3'b100, 32'h0,
                 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0};
      vt[1]  = '{1'b0, 32'h100, 32'h0, 3'b100, 32'hDEADBEEF,
                 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b0, 32'h101, 32'h0, 3'b100, 32'h11111111,
                 4'b0000, 32'h0, 32'h0, 1'b1};
      vt[3]  = '{1'b0, 32'h103, 32'h0, 3'b000, 32'h123456F0,
                 4'b0001, 32'h0, 32'hFFFFFFF0, 1'b0};
      vt[4]  = '{1'b0, 32'h103, 32'h0, 3'b001, 32'h123456F0,
                 4'b0001, 32'h0, 32'h000000F0, 1'b0};
      vt[5]  = '{1'b1, 32'h102, 32'h0000ABCD, 3'b010, 32'h0,
                 4'b0011, 32'hABCDABCD, 32'h0, 1'b0};
      vt[6]  = '{1'b0, 32'h102, 32'h0, 3'b010, 32'h12348001,
                 4'b0011, 32'h0, 32'hFFFF8001, 1'b0};
      vt[7]  = '{1'b0, 32'h100, 32'h0, 3'b011, 32'h80011234,
                 4'b1100, 32'h0, 32'h00008001, 1'b0};
      vt[8]  = '{1'b0, 32'h103, 32'h0, 3'b010, 32'h22222222,
                 4'b0000, 32'h0, 32'h0, 1'b1};
      vt[9]  = '{1'b1, 32'h101, 32'h1234567A, 3'b000, 32'h0,
                 4'b0100, 32'h7A7A7A7A, 32'h0, 1'b0};
      vt[10] = '{1'b0, 32'h200, 32'h0, 3'b000, 32'h7F000000,
                 4'b1000, 32'h0, 32'h0000007F, 1'b0};
      vt[11] = '{1'b0, 32'h100, 32'h0, 3'b110, 32'h33333333,
                 4'b0000, 32'h0, 32'h0, 1'b1};

      reset2 = 1'b1; reset7 = 1'b1; sel7 = 1'b0;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0; info = '0;
      rd_word = '0;
      repeat (2) @(negedge clk);
      reset2 = 1'b0;
      @(negedge clk);
      #1;
      chk("reset done", done2, 0);
      chk("reset misalign", mis2, 0);
      chk("reset sram_en", en2, 0);
      chk("reset rdata", rdata2, 0);
      chk("reset reg_lock", lock2, 0);

      for (int i = 0; i < 12; i++) begin
         run_vec(vt[i], 2, $sformatf("vec%0d", i));
      end

      // back-to-back with req held through DONE
      n_vec++;
      dmask = '0; emask = '0; b2b_rd = '0;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h100; wdata = 32'h0BADF00D;
      info = 3'b100; rd_word = 32'h0;
      for (int c = 0; c < 11; c++) begin
         #1;
         if (a_done) begin
            dmask[c] = 1'b1;
            b2b_rd = a_rd;
         end
         if (a_en) emask[c] = 1'b1;
         if (c == 2) begin
            we = 1'b0; addr = 32'h104; wdata = 32'h0;
            rd_word = 32'h55AA55AA;
         end
         @(negedge clk);
         if (c == 7) req = 1'b0;
      end
      chk("b2b done_cycles", dmask, 16'h0084);
      chk("b2b issue_cycles", emask, 16'h0012);
      chk("b2b rdata", b2b_rd, 32'h55AA55AA);

      // reset in WAIT on the LATENCY=7 instance
      n_vec++;
      @(negedge clk);
      reset2 = 1'b1; sel7 = 1'b1;
      @(negedge clk);
      reset7 = 1'b0;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h100; info = 3'b100;
      wdata = '0; rd_word = 32'h13579BDF;
      repeat (3) @(negedge clk);
      #1;
      chk("rstwait lock_in_wait", lock7, 1);
      reset7 = 1'b1; req = 1'b0;
      @(negedge clk);
      #1;
      chk("rstwait done", done7, 0);
      chk("rstwait reg_lock", lock7, 0);
      chk("rstwait rdata", rdata7, 0);
      reset7 = 1'b0;
      n_done = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         if (done7 || en7) n_done++;
      end
      chk("rstwait no_late_activity", n_done, 0);

      v7 = '{1'b0, 32'h101, 32'h0, 3'b001, 32'h11F23344,
             4'b0100, 32'h0, 32'h000000F2, 1'b0};
      run_vec(v7, 7, "lat7 byte");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 2, SHALL set the SRAM read latency in cycles; legal range 1..7.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  1  memory-stage access request, level, held until done.
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 addr  in  [0:31]  byte address, big-endian; bit 0 is MSB.
REQ-007 wdata  in  [0:31]  store data, right-justified.
REQ-008 dmem_info  in  [0:2]  [0:1] size (00 byte, 01 half, 10 word, 11 reserved); [2] 1 = unsigned load.
REQ-009 rdata  out  [0:31]  load result, extended to 32 bits.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 misalign  out  1  one-cycle error pulse, coincident with done.
REQ-012 reg_lock  out  1  pipeline stall request.
REQ-013 sram_en  out  1; sram_we  out  1; sram_addr  out  [0:29] word address; sram_be  out  [0:3] byte enables, lane 0 = bits [0:7]; sram_wdata  out  [0:31].
REQ-014 sram_rdata  in  [0:31]  valid exactly LATENCY cycles after an sram_en read cycle.

Function
REQ-015 The FSM SHALL have four states: IDLE, ISSUE, WAIT, DONE.
REQ-016 IDLE with req=1 and aligned access: capture we/addr/wdata/dmem_info, go to ISSUE.
REQ-017 IDLE with req=1 and misaligned access (half with addr[31]=1; word with addr[30:31]!=00; size 11 at any address): go to DONE with the error flag set, no SRAM access.
REQ-018 ISSUE: sram_en=1 for exactly this one cycle, driving sram_we, sram_addr=addr[0:29], sram_be, sram_wdata; store goes to DONE, load loads counter with LATENCY and goes to WAIT.
REQ-019 WAIT: decrement the counter each cycle; on the cycle the counter reaches 1, register sram_rdata through lane alignment into rdata and go to DONE.
REQ-020 DONE: done=1, misalign=error flag; the next state SHALL be IDLE unconditionally, and req SHALL be ignored in DONE.
REQ-021 Load timing: req first seen in cycle 0 -> ISSUE in cycle 1 -> done in cycle 2+LATENCY.
REQ-022 Store timing: req first seen in cycle 0 -> done in cycle 2.
REQ-023 Error timing: req first seen in cycle 0 -> done and misalign in cycle 1.
REQ-024 reg_lock SHALL be combinational: 1 in IDLE when req=1, 1 in ISSUE and WAIT, 0 in DONE; this holds the pipeline until the completing cycle.
REQ-025 Byte lane mapping: lane = addr[30:31]; 00 selects bits [0:7].
REQ-026 Store byte: sram_be one-hot at the lane; sram_wdata = wdata[24:31] replicated on all four lanes.
REQ-027 Store half: sram_be = 1100 for addr[30]=0, 0011 for addr[30]=1; sram_wdata = wdata[16:31] replicated.
REQ-028 Store word: sram_be = 1111; sram_wdata = wdata.
REQ-029 Load: rdata = the selected byte or half, sign-extended when dmem_info[2]=0 and zero-extended when dmem_info[2]=1; word loads pass through unchanged.
REQ-030 rdata SHALL hold its value until the next load completes; stores and errors SHALL set rdata to 0.
REQ-031 With sram_en=0, sram_we, sram_be and sram_wdata SHALL be 0.

Reset
REQ-032 reset=1 SHALL force IDLE and clear the counter, error flag and rdata, and drive done, misalign and sram_en to 0 in the following cycle; reg_lock then follows REQ-024.
REQ-033 reset asserted during ISSUE or WAIT SHALL abandon the access, produce no done pulse, and ignore any late sram_rdata.

Structure
REQ-034 A shared package dmem_defs SHALL hold the state encoding, the size codes (SZ_BYTE, SZ_HALF, SZ_WORD) and the LATENCY bounds; the pipeline memory stage SHALL use the same package.
REQ-035 Byte-lane steering, byte-enable generation and extension SHALL live in one combinational sub-module, dmem_lane_align, instantiated once.

Verification
REQ-036 Store word: addr=0x100, wdata=0xDEADBEEF -> sram_be=1111, sram_addr=0x40, done in cycle 2; a following word load to 0x100 with LATENCY=2 -> rdata=0xDEADBEEF in cycle 4, reg_lock high cycles 0..3.
REQ-037 Signed byte load: addr=0x103 with SRAM word 0x123456F0 -> rdata=0xFFFFFFF0; the same load with dmem_info[2]=1 -> rdata=0x000000F0.
REQ-038 Store half: addr=0x102, wdata=0x0000ABCD -> sram_be=0011, sram_wdata=0xABCDABCD.
REQ-039 Misaligned word load: addr=0x101 -> no sram_en, done=misalign=1 in cycle 1, rdata=0.
REQ-040 Reset in WAIT with LATENCY=7 -> no done pulse, IDLE next cycle, reg_lock=0 with req=0; the following access completes normally.
REQ-041 Back-to-back requests with req held high through DONE -> DONE is followed by IDLE, the second access is accepted exactly one cycle later, and each access gets exactly one done pulse.
